iobus_event_fifo: RTL and testbench

// Memory-mapped IOBUS responder that queues input events (debounced button codes,
// e.g. snake direction presses) for the OTTER CPU to consume. Event sources push

---
 rtl/iobus_event_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_iobus_event_fifo.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_event_fifo.sv
// ---------------------------------------------------------------------------
// iobus_event_fifo
//
// Memory-mapped IOBUS responder that queues input event codes (for example
// debounced button presses) for the OTTER CPU. Event sources push codes. The
// CPU reads the head of the queue through the wrapper's IOBUS read mux and
// pops it by writing to the DATA address.
//
// Register map:
//   BASE_AD     DATA   read : {valid, zeros, head_code}; the whole word is 0 when empty
//                      write: pop the head (the write data is ignored)
//   BASE_AD+4   STATUS read : {ovf[31], full[30], empty[29], zeros, count[7:0]}
//                      write: bit0 = clear ovf, bit1 = flush the queue
//
// Ports:
//   CLK            system clock; all state changes on the rising edge
//   RST_N          asynchronous, active-low reset
//   EVT_VALID      push request, one event per cycle while high
//   EVT_CODE       event code, sampled when EVT_VALID=1
//   IOBUS_ADDR     CPU IOBUS address
//   IOBUS_OUT      CPU IOBUS write data
//   IOBUS_WR       CPU IOBUS write strobe
//   IOBUS_RD_DATA  combinational read data for the wrapper input mux
//   IOBUS_HIT      high when IOBUS_ADDR selects DATA or STATUS
//   INTR           one-cycle pulse after the queue goes from empty to non-empty
//
// Event handshake: EVT_VALID has no ready. Each cycle EVT_VALID is high offers
// exactly one event. The event is accepted when the queue has room, or when a
// pop happens on the same edge. An event offered while the queue stays full is
// dropped and sets the sticky ovf bit. A flush on the same edge discards the
// event and leaves ovf unchanged.
// ---------------------------------------------------------------------------
module iobus_event_fifo #(
  parameter int          DEPTH   = 8,
  parameter int          CODE_W  = 4,
  parameter logic [31:0] BASE_AD = 32'h1100_0080
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EVT_VALID,
  input  logic [CODE_W-1:0] EVT_CODE,
  input  logic [31:0]       IOBUS_ADDR,
  input  logic [31:0]       IOBUS_OUT,
  input  logic              IOBUS_WR,
  output logic [31:0]       IOBUS_RD_DATA,
  output logic              IOBUS_HIT,
  output logic              INTR
);

  localparam int          PTR_W   = $clog2(DEPTH);
  localparam int          CNT_W   = PTR_W + 1;
  localparam logic [31:0] STAT_AD = BASE_AD + 32'd4;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic              intr_q,   intr_d;
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];

  // -------------------------------------------------------------------------
  // Address decode and request qualification
  // -------------------------------------------------------------------------
  logic hit_data, hit_stat;
  logic wr_data, wr_stat;
  logic flush, ovf_clr;
  logic empty, full;
  logic pop_ok, push_ok, ovf_set;

  // Only the two low bits of a STATUS write carry meaning.
  logic unused_iobus_out;
  assign unused_iobus_out = ^IOBUS_OUT[31:2];

  always_comb begin
    hit_data = (IOBUS_ADDR == BASE_AD);
    hit_stat = (IOBUS_ADDR == STAT_AD);
    wr_data  = IOBUS_WR && hit_data;
    wr_stat  = IOBUS_WR && hit_stat;
    flush    = wr_stat && IOBUS_OUT[1];
    ovf_clr  = wr_stat && IOBUS_OUT[0];

    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));

    // A pop on an empty queue does nothing. A flush and a pop can never
    // coincide because they decode to different addresses.
    pop_ok   = wr_data && !empty;

    // A full queue still accepts an event when the head leaves on the same
    // edge. A flush discards any event offered alongside it.
    push_ok  = EVT_VALID && !flush && (!full || pop_ok);

    // A drop sets ovf. The flush case is excluded because that event is
    // discarded rather than overflowed.
    ovf_set  = EVT_VALID && !flush && full && !pop_ok;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    intr_d   = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // When the same edge both sets and clears ovf, the set wins so that a
    // drop is never hidden.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    // Pulse only on the empty to non-empty transition.
    intr_d = empty && (count_d != '0);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = EVT_CODE;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      intr_q   <= intr_d;
    end
  end

  // Storage is not reset. The count and pointers alone decide what is valid.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // -------------------------------------------------------------------------
  // Combinational read path (a read has no side effects)
  // -------------------------------------------------------------------------
  logic [31:0] data_word;
  logic [31:0] stat_word;

  always_comb begin
    data_word = '0;
    if (!empty) begin
      data_word[31]         = 1'b1;
      data_word[CODE_W-1:0] = mem_q[rd_ptr_q];
    end

    stat_word       = '0;
    stat_word[31]   = ovf_q;
    stat_word[30]   = full;
    stat_word[29]   = empty;
    stat_word[7:0]  = 8'(count_q);

    IOBUS_HIT     = hit_data || hit_stat;
    IOBUS_RD_DATA = '0;
    if (hit_data) begin
      IOBUS_RD_DATA = data_word;
    end else if (hit_stat) begin
      IOBUS_RD_DATA = stat_word;
    end
  end

  assign INTR = intr_q;

endmodule

// File: tb/tb_iobus_event_fifo.sv
module tb_iobus_event_fifo;

  localparam int          DEPTH   = 8;
  localparam int          CODE_W  = 4;
  localparam logic [31:0] BASE_AD = 32'h1100_0080;
  localparam logic [31:0] STAT_AD = 32'h1100_0084;

  logic              CLK;
  logic              RST_N;
  logic              EVT_VALID;
  logic [CODE_W-1:0] EVT_CODE;
  logic [31:0]       IOBUS_ADDR;
  logic [31:0]       IOBUS_OUT;
  logic              IOBUS_WR;
  logic [31:0]       IOBUS_RD_DATA;
  logic              IOBUS_HIT;
  logic              INTR;

  iobus_event_fifo #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W),
    .BASE_AD(BASE_AD)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .EVT_VALID    (EVT_VALID),
    .EVT_CODE     (EVT_CODE),
    .IOBUS_ADDR   (IOBUS_ADDR),
    .IOBUS_OUT    (IOBUS_OUT),
    .IOBUS_WR     (IOBUS_WR),
    .IOBUS_RD_DATA(IOBUS_RD_DATA),
    .IOBUS_HIT    (IOBUS_HIT),
    .INTR         (INTR)
  );

  // ---------------------------------------------------------------- clock/reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ------------------------------------------------------------------ scoreboard
  logic [31:0] exp_q[$];   // expected DATA words, head first
  bit          model_ovf;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = '0;
    s[31]   = model_ovf;
    s[30]   = (exp_q.size() == DEPTH);
    s[29]   = (exp_q.size() == 0);
    s[7:0]  = 8'(exp_q.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_data();
    if (exp_q.size() == 0) return 32'h0;
    return exp_q[0];
  endfunction

  // ------------------------------------------------------------------ drivers
  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data,
                          output logic hit);
    IOBUS_ADDR = addr;
    IOBUS_WR   = 1'b0;
    #1;
    data = IOBUS_RD_DATA;
    hit  = IOBUS_HIT;
    IOBUS_ADDR = 32'h0;
  endtask

  // One clock cycle. It may offer an event, pop through DATA, or write
  // STATUS (pop and STATUS write are never requested together). It records
  // the head seen before the edge, the head the model expected, and whether
  // INTR must pulse after the edge.
  task automatic cycle(input bit ev, input logic [CODE_W-1:0] code,
                       input bit pop, input bit sw, input logic [1:0] sv,
                       output logic [31:0] seen, output logic [31:0] want,
                       output bit intr_want);
    int n;
    bit flush, pop_ok, push_ok;
    n       = exp_q.size();
    flush   = sw && sv[1];
    pop_ok  = pop && (n != 0);
    push_ok = ev && !flush && ((n < DEPTH) || pop_ok);

    EVT_VALID  = ev;
    EVT_CODE   = code;
    IOBUS_WR   = pop || sw;
    IOBUS_ADDR = pop ? BASE_AD : (sw ? STAT_AD : 32'h0);
    // On a pop, drive noise with bit1 set: a DATA write must ignore it.
    IOBUS_OUT  = sw ? {30'b0, sv} : ($urandom() | 32'h3);
    #1;
    seen = IOBUS_RD_DATA;
    want = 32'h0;
    if (pop_ok) want = exp_q.pop_front();

    if (ev && !flush && (n == DEPTH) && !pop_ok) model_ovf = 1'b1;
    else if (sw && sv[0])                        model_ovf = 1'b0;
    if (flush) exp_q.delete();
    if (push_ok) exp_q.push_back({1'b1, {(31-CODE_W){1'b0}}, code});
    intr_want = (n == 0) && (exp_q.size() != 0);

    @(posedge CLK);
    #1;
    EVT_VALID  = 1'b0;
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = 32'h0;
    IOBUS_OUT  = 32'h0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [31:0] d, seen, want;
    logic        h;
    bit          iw;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    #1;
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== 32'h2000_0000) begin
      n_fail++; $display("FAIL reset_status got=%h exp=%h", d, 32'h2000_0000);
    end
    // three events queued, then reset in the middle of the stream
    cycle(1, 4'hA, 0, 0, 2'b00, seen, want, iw);
    cycle(1, 4'hB, 0, 0, 2'b00, seen, want, iw);
    cycle(1, 4'hC, 0, 0, 2'b00, seen, want, iw);
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== 32'h0000_0003) begin
      n_fail++; $display("FAIL prereset_status got=%h exp=%h", d, 32'h0000_0003);
    end
    RST_N = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    #1;
    read_reg(BASE_AD, d, h);
    n_checks++;
    if (d !== 32'h0 || h !== 1'b1) begin
      n_fail++; $display("FAIL reset_data got=%h/%b exp=%h/1", d, h, 32'h0);
    end
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== 32'h2000_0000 || h !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_status got=%h/%b exp=%h/1", d, h, 32'h2000_0000);
    end
    n_checks++;
    if (INTR !== 1'b0) begin
      n_fail++; $display("FAIL reset_intr got=%b exp=0", INTR);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    #1;
    // unmapped address: no hit, zero data
    read_reg(STAT_AD + 32'd4, d, h);
    n_checks++;
    if (d !== 32'h0 || h !== 1'b0) begin
      n_fail++; $display("FAIL unmapped got=%h/%b exp=%h/0", d, h, 32'h0);
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] d, seen, want;
    logic        h;
    bit          iw;
    logic [3:0]  codes [3];
    logic [31:0] lits  [3];
    codes[0] = 4'd3; codes[1] = 4'd1; codes[2] = 4'd2;
    lits[0] = 32'h8000_0003; lits[1] = 32'h8000_0001; lits[2] = 32'h8000_0002;
    for (int i = 0; i < 3; i++) begin
      cycle(1, codes[i], 0, 0, 2'b00, seen, want, iw);
      n_checks++;
      if (INTR !== iw) begin
        n_fail++; $display("FAIL push_intr[%0d] got=%b exp=%b", i, INTR, iw);
      end
    end
    cycle(0, 4'd0, 0, 0, 2'b00, seen, want, iw);
    n_checks++;
    if (INTR !== 1'b0) begin
      n_fail++; $display("FAIL idle_intr got=%b exp=0", INTR);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 4'd0, 1, 0, 2'b00, seen, want, iw);
      n_checks++;
      if (seen !== want || seen !== lits[i]) begin
        n_fail++; $display("FAIL pop[%0d] got=%h exp=%h", i, seen, want);
      end
    end
    read_reg(BASE_AD, d, h);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL drained_data got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, seen, want;
    logic        h;
    bit          iw;
    for (int i = 0; i < 9; i++) cycle(1, 4'(i), 0, 0, 2'b00, seen, want, iw);
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== exp_status() || d !== 32'hC000_0008) begin
      n_fail++; $display("FAIL ovf_status got=%h exp=%h", d, 32'hC000_0008);
    end
    // clear and overflowing push on the same edge: the set wins
    cycle(1, 4'hF, 0, 1, 2'b01, seen, want, iw);
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== 32'hC000_0008) begin
      n_fail++; $display("FAIL ovf_set_wins got=%h exp=%h", d, 32'hC000_0008);
    end
    cycle(0, 4'd0, 0, 1, 2'b01, seen, want, iw);
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== exp_status() || d !== 32'h4000_0008) begin
      n_fail++; $display("FAIL ovf_clear got=%h exp=%h", d, 32'h4000_0008);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d, seen, want;
    logic        h;
    bit          iw;
    cycle(1, 4'd5, 1, 0, 2'b00, seen, want, iw);
    n_checks++;
    if (seen !== want) begin
      n_fail++; $display("FAIL full_pp_head got=%h exp=%h", seen, want);
    end
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== 32'h4000_0008) begin
      n_fail++; $display("FAIL full_pp_status got=%h exp=%h", d, 32'h4000_0008);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 4'd0, 1, 0, 2'b00, seen, want, iw);
      n_checks++;
      if (seen !== want) begin
        n_fail++; $display("FAIL drain[%0d] got=%h exp=%h", i, seen, want);
      end
    end
    n_checks++;
    if (seen !== 32'h8000_0005) begin
      n_fail++; $display("FAIL last_code got=%h exp=%h", seen, 32'h8000_0005);
    end
  endtask

  task automatic test_empty_push_pop();
    logic [31:0] d, seen, want;
    logic        h;
    bit          iw;
    cycle(1, 4'd7, 1, 0, 2'b00, seen, want, iw);
    n_checks++;
    if (INTR !== 1'b1 || iw !== 1'b1) begin
      n_fail++; $display("FAIL empty_pp_intr got=%b exp=1", INTR);
    end
    read_reg(BASE_AD, d, h);
    n_checks++;
    if (d !== 32'h8000_0007 || d !== exp_data()) begin
      n_fail++; $display("FAIL empty_pp_data got=%h exp=%h", d, 32'h8000_0007);
    end
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== 32'h0000_0001) begin
      n_fail++; $display("FAIL empty_pp_status got=%h exp=%h", d, 32'h0000_0001);
    end
    cycle(0, 4'd0, 0, 0, 2'b00, seen, want, iw);
    n_checks++;
    if (INTR !== 1'b0) begin
      n_fail++; $display("FAIL empty_pp_intr_drop got=%b exp=0", INTR);
    end
  endtask

  task automatic test_wrap_flush();
    logic [31:0] d, seen, want;
    logic        h;
    bit          iw, ev, pop;
    logic [3:0]  code;
    for (int i = 0; i < 20; i++) begin
      ev   = ($urandom_range(0, 3) != 0);
      pop  = ($urandom_range(0, 3) != 0);
      code = 4'($urandom_range(0, 15));
      cycle(ev, code, pop, 0, 2'b00, seen, want, iw);
      if (pop) begin
        n_checks++;
        if (seen !== want) begin
          n_fail++; $display("FAIL wrap_pop[%0d] got=%h exp=%h", i, seen, want);
        end
      end
      n_checks++;
      if (INTR !== iw) begin
        n_fail++; $display("FAIL wrap_intr[%0d] got=%b exp=%b", i, INTR, iw);
      end
    end
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== exp_status()) begin
      n_fail++; $display("FAIL wrap_status got=%h exp=%h", d, exp_status());
    end
    // fill past full so ovf is set, then flush with an event offered
    while (exp_q.size() < DEPTH) cycle(1, 4'($urandom_range(0, 15)), 0, 0, 2'b00, seen, want, iw);
    cycle(1, 4'hE, 0, 0, 2'b00, seen, want, iw);
    cycle(1, 4'hD, 0, 1, 2'b10, seen, want, iw);
    read_reg(STAT_AD, d, h);
    n_checks++;
    if (d !== exp_status() || d !== 32'hA000_0000) begin
      n_fail++; $display("FAIL flush_status got=%h exp=%h", d, 32'hA000_0000);
    end
    n_checks++;
    if (INTR !== 1'b0) begin
      n_fail++; $display("FAIL flush_intr got=%b exp=0", INTR);
    end
    cycle(1, 4'h6, 0, 0, 2'b00, seen, want, iw);
    n_checks++;
    if (INTR !== 1'b1) begin
      n_fail++; $display("FAIL post_flush_intr got=%b exp=1", INTR);
    end
    cycle(0, 4'd0, 1, 0, 2'b00, seen, want, iw);
    n_checks++;
    if (seen !== want || seen !== 32'h8000_0006) begin
      n_fail++; $display("FAIL post_flush_pop got=%h exp=%h", seen, 32'h8000_0006);
    end
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    model_ovf  = 1'b0;
    RST_N      = 1'b0;
    EVT_VALID  = 1'b0;
    EVT_CODE   = '0;
    IOBUS_ADDR = 32'h0;
    IOBUS_OUT  = 32'h0;
    IOBUS_WR   = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap_flush();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
